// File: rtl/csr_unit_mw.sv
// Machine-mode CSR file and trap controller for the Memory/Writeback stage.
// Executes Zicsr ops and MRET, takes timer/external interrupts, and drives the flush/redirect strobe.
module csr_unit_mw #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction_DE,
    input  logic [31:0] ALU_result_DE,
    input  logic [31:0] PC_F,
    input  logic        Stall_MW,
    input  logic        timer_irq,
    input  logic        ext_irq,
    output logic [31:0] csr_rdata,
    output logic        csr_flush,
    output logic [31:0] csr_redirect
);
    localparam logic [6:0]  OP_SYSTEM = 7'b1110011;
    localparam logic [31:0] MRET_INSN = 32'h3020_0073;
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MIP     = 12'h344;
    localparam logic [11:0] A_MCYCLE  = 12'hB00;
    localparam logic [11:0] A_MCYCLEH = 12'hB80;

    typedef enum logic {RUN, DRAIN} state_e;

    state_e      state_q, state_d;
    logic        mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mie_d, mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d, mcycle_inc;

    logic [11:0] addr;
    logic [1:0]  op;
    logic        csr_op, is_mret, wr_en, irq_pend, ext_pend, take_mret, take_irq;
    logic [31:0] mip_w, csr_old, wnew;
    logic        unused_ok;

    assign addr      = Instruction_DE[31:20];
    assign op        = Instruction_DE[13:12];
    assign csr_op    = (Instruction_DE[6:0] == OP_SYSTEM) && (op != 2'b00);
    assign is_mret   = (Instruction_DE == MRET_INSN);
    assign unused_ok = ^{Instruction_DE[14], Instruction_DE[11:7], PC_F[1:0]};

    // Set/clear with rs1 == x0 are pure reads and must not touch the CSR.
    assign wr_en = rst && csr_op && !Stall_MW && ((op == 2'b01) || (Instruction_DE[19:15] != 5'd0));

    assign mip_w     = {20'd0, ext_irq, 3'd0, timer_irq, 7'd0};
    assign irq_pend  = mst_mie_q && ((mie_q & mip_w) != 32'd0);
    assign ext_pend  = ext_irq && mie_q[11];
    assign take_mret = rst && (state_q == RUN) && !Stall_MW && is_mret;
    assign take_irq  = rst && (state_q == RUN) && !Stall_MW && !is_mret && irq_pend;

    always_comb begin
        csr_old = 32'd0;
        case (addr)
            A_MSTATUS: csr_old = {24'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};
            A_MIE:     csr_old = mie_q;
            A_MTVEC:   csr_old = mtvec_q;
            A_MEPC:    csr_old = mepc_q;
            A_MCAUSE:  csr_old = mcause_q;
            A_MIP:     csr_old = mip_w;
            A_MCYCLE:  csr_old = mcycle_q[31:0];
            A_MCYCLEH: csr_old = mcycle_q[63:32];
            default:   csr_old = 32'd0;
        endcase
    end

    always_comb begin
        wnew = csr_old;
        case (op)
            2'b01:   wnew = ALU_result_DE;
            2'b10:   wnew = csr_old | ALU_result_DE;
            2'b11:   wnew = csr_old & ~ALU_result_DE;
            default: wnew = csr_old;
        endcase
    end

    assign csr_rdata    = (rst && csr_op) ? csr_old : 32'd0;
    assign csr_flush    = take_mret || take_irq;
    assign csr_redirect = take_mret ? mepc_q : (take_irq ? mtvec_q : 32'd0);

    always_comb begin
        state_d    = RUN;
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_inc = mcycle_q + 64'd1;
        mcycle_d   = mcycle_inc;
        if (wr_en) begin
            case (addr)
                A_MSTATUS: begin mst_mie_d = wnew[3]; mst_mpie_d = wnew[7]; end
                A_MIE:     mie_d    = wnew & 32'h0000_0880;
                A_MTVEC:   mtvec_d  = {wnew[31:2], 2'b00};
                A_MEPC:    mepc_d   = {wnew[31:2], 2'b00};
                A_MCAUSE:  mcause_d = wnew;
                // The other half keeps counting, so a low-half write still carries upward.
                A_MCYCLE:  mcycle_d = {mcycle_inc[63:32], wnew};
                A_MCYCLEH: mcycle_d = {wnew, mcycle_inc[31:0]};
                default:   ;
            endcase
        end
        // Trap side effects land after the retiring CSR op, so they override its mstatus/mepc/mcause write.
        if (take_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
            state_d    = DRAIN;
        end else if (take_irq) begin
            mepc_d     = {PC_F[31:2], 2'b00};
            mcause_d   = ext_pend ? 32'h8000_000B : 32'h8000_0007;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
            state_d    = DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= {RESET_MTVEC[31:2], 2'b00};
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mcycle_q   <= 64'd0;
        end else begin
            state_q    <= state_d;
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
        end
    end
endmodule

// File: tb/tb_csr_unit_mw.sv
// Bench for csr_unit_mw: directed vector table, then random traffic against a behavioural CSR/trap model.
module tb_csr_unit_mw;
    localparam logic [31:0] RMT  = 32'h0000_0200;
    localparam logic [31:0] MRET = 32'h3020_0073;
    localparam logic [11:0] MST = 12'h300, MIE = 12'h304, MTV = 12'h305, MEP = 12'h341;
    localparam logic [11:0] MCA = 12'h342, MIP = 12'h344, MCY = 12'hB00, MCH = 12'hB80;

    logic        clk = 1'b0;
    logic        rst, stall, tirq, eirq;
    logic [31:0] instr, alu, pcf;
    logic [31:0] csr_rdata, csr_redirect;
    logic        csr_flush;

    always #5 clk = ~clk;

    csr_unit_mw #(.RESET_MTVEC(RMT)) dut (
        .clk(clk), .rst(rst), .Instruction_DE(instr), .ALU_result_DE(alu), .PC_F(pcf),
        .Stall_MW(stall), .timer_irq(tirq), .ext_irq(eirq),
        .csr_rdata(csr_rdata), .csr_flush(csr_flush), .csr_redirect(csr_redirect)
    );

    int n_cmp = 0, n_bad = 0;

    // Architectural model: whole CSR values plus a single "just redirected" flag.
    logic [31:0] m_mstatus = 0, m_mie = 0, m_mtvec = 0, m_mepc = 0, m_mcause = 0;
    logic [63:0] m_cyc = 0;
    logic        m_drain = 0;
    logic        s_ef, s_mret;
    logic [31:0] s_cause;

    typedef struct {
        logic r; logic [31:0] i, a, p; logic s, t, e;
        logic [31:0] erd; logic ef; logic [31:0] edr;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [31:0] enc(input logic [11:0] ad, input logic [4:0] rs1, input logic [2:0] f3);
        return {ad, rs1, f3, 5'd1, 7'b1110011};
    endfunction

    function automatic logic [31:0] rd(input logic [11:0] ad);
        return enc(ad, 5'd0, 3'b010);
    endfunction

    function automatic vec_t mk(input logic r, input logic [31:0] i, a, p, input logic s, t, e,
                                input logic [31:0] erd, input logic ef, input logic [31:0] edr);
        vec_t v;
        v.r = r; v.i = i; v.a = a; v.p = p; v.s = s; v.t = t; v.e = e;
        v.erd = erd; v.ef = ef; v.edr = edr;
        return v;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] ad);
        case (ad)
            MST: return m_mstatus;
            MIE: return m_mie;
            MTV: return m_mtvec;
            MEP: return m_mepc;
            MCA: return m_mcause;
            MIP: return (eirq ? 32'h800 : 32'h0) | (tirq ? 32'h80 : 32'h0);
            MCY: return m_cyc[31:0];
            MCH: return m_cyc[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic sample(input string nm);
        logic [31:0] mipv, er;
        logic        csr, pend;
        @(negedge clk);
        mipv   = (eirq ? 32'h800 : 32'h0) | (tirq ? 32'h80 : 32'h0);
        csr    = (instr[6:0] == 7'h73) && (instr[13:12] != 2'b00);
        s_mret = (instr == MRET);
        pend   = m_mstatus[3] && ((m_mie & mipv) != 32'h0);
        s_ef   = rst && !m_drain && !stall && (s_mret || pend);
        s_cause = (eirq && m_mie[11]) ? 32'h8000_000B : 32'h8000_0007;
        er     = (rst && csr) ? m_read(instr[31:20]) : 32'h0;
        chk({nm, " rdata"}, csr_rdata, er);
        chk({nm, " flush"}, {31'd0, csr_flush}, {31'd0, s_ef});
        if (s_ef) chk({nm, " redirect"}, csr_redirect, s_mret ? m_mepc : m_mtvec);
    endtask

    task automatic advance();
        logic [31:0] old_ms, old, nv;
        logic [63:0] nc;
        logic [11:0] ad;
        @(posedge clk);
        if (!rst) begin
            m_mstatus = 0; m_mie = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0;
            m_mtvec = RMT & ~32'h3; m_drain = 0;
        end else begin
            old_ms = m_mstatus;
            nc = m_cyc + 64'd1;
            ad = instr[31:20];
            if (instr[6:0] == 7'h73 && instr[13:12] != 2'b00 && !stall &&
                (instr[13:12] == 2'b01 || instr[19:15] != 5'd0)) begin
                old = m_read(ad);
                case (instr[13:12])
                    2'b01:   nv = alu;
                    2'b10:   nv = old | alu;
                    default: nv = old & ~alu;
                endcase
                case (ad)
                    MST: m_mstatus = nv & 32'h88;
                    MIE: m_mie     = nv & 32'h880;
                    MTV: m_mtvec   = nv & ~32'h3;
                    MEP: m_mepc    = nv & ~32'h3;
                    MCA: m_mcause  = nv;
                    MCY: nc = (nc & 64'hFFFF_FFFF_0000_0000) | {32'd0, nv};
                    MCH: nc = {nv, nc[31:0]};
                    default: ;
                endcase
            end
            m_cyc = nc;
            if (s_ef) begin
                if (s_mret) m_mstatus = old_ms[7] ? 32'h88 : 32'h80;
                else begin
                    m_mepc    = pcf & ~32'h3;
                    m_mcause  = s_cause;
                    m_mstatus = old_ms[3] ? 32'h80 : 32'h0;
                end
            end
            m_drain = s_ef;
        end
        #1;
    endtask

    initial begin
        rst = 0; instr = 0; alu = 0; pcf = 0; stall = 0; tirq = 0; eirq = 0;
        // reset with irqs high
        tbl.push_back(mk(0, rd(MTV), 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, rd(MTV), 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, rd(MCY), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, rd(MCY), 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, rd(MTV), 0, 0, 0, 0, 0, RMT, 0, 0));
        tbl.push_back(mk(1, 32'h305110F3, 32'h103, 0, 0, 0, 0, RMT, 0, 0));
        tbl.push_back(mk(1, rd(MTV), 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(mk(1, enc(MST, 2, 3'b001), 32'h8, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, enc(MIE, 2, 3'b001), 32'h80, 0, 0, 0, 0, 0, 0, 0));
        // timer trap, then drain
        tbl.push_back(mk(1, 0, 0, 32'h40, 0, 1, 0, 0, 1, 32'h100));
        tbl.push_back(mk(1, rd(MEP), 0, 0, 0, 1, 0, 32'h40, 0, 0));
        tbl.push_back(mk(1, rd(MCA), 0, 0, 0, 1, 0, 32'h8000_0007, 0, 0));
        tbl.push_back(mk(1, rd(MST), 0, 0, 0, 0, 0, 32'h80, 0, 0));
        // mret
        tbl.push_back(mk(1, MRET, 0, 0, 0, 0, 0, 0, 1, 32'h40));
        tbl.push_back(mk(1, rd(MST), 0, 0, 0, 0, 0, 32'h88, 0, 0));
        // mret beats a pending external irq, ext trap follows the drain cycle
        tbl.push_back(mk(1, enc(MST, 2, 3'b001), 32'h88, 0, 0, 0, 0, 32'h88, 0, 0));
        tbl.push_back(mk(1, enc(MIE, 2, 3'b001), 32'h800, 0, 0, 0, 0, 32'h80, 0, 0));
        tbl.push_back(mk(1, MRET, 0, 32'h60, 0, 0, 1, 0, 1, 32'h40));
        tbl.push_back(mk(1, 0, 0, 32'h60, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h64, 0, 0, 1, 0, 1, 32'h100));
        tbl.push_back(mk(1, rd(MCA), 0, 0, 0, 0, 1, 32'h8000_000B, 0, 0));
        tbl.push_back(mk(1, rd(MEP), 0, 0, 0, 0, 1, 32'h64, 0, 0));
        // stall blocks both the trap and the write
        tbl.push_back(mk(1, enc(MST, 2, 3'b001), 32'h8, 0, 0, 0, 1, 32'h80, 0, 0));
        tbl.push_back(mk(1, 32'h305110F3, 32'h300, 0, 1, 0, 1, 32'h100, 0, 0));
        tbl.push_back(mk(1, rd(MTV), 0, 0, 0, 0, 0, 32'h100, 0, 0));
        tbl.push_back(mk(1, rd(MIP), 0, 0, 1, 1, 1, 32'h880, 0, 0));
        // mcycle wrap and carry on low-half write
        tbl.push_back(mk(1, enc(MCY, 2, 3'b001), 32'hFFFF_FFFF, 0, 0, 0, 0, 24, 0, 0));
        tbl.push_back(mk(1, rd(MCY), 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(1, rd(MCH), 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, rd(MCY), 0, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, enc(MCY, 2, 3'b001), 32'hFFFF_FFFF, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, enc(MCY, 2, 3'b001), 32'h5, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(1, rd(MCH), 0, 0, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(1, rd(MCY), 0, 0, 0, 0, 0, 6, 0, 0));
        // set with rs1=x0 is read-only; clear; unimplemented; mepc alignment
        tbl.push_back(mk(1, enc(MIE, 0, 3'b110), 32'hFFFF, 0, 0, 0, 0, 32'h800, 0, 0));
        tbl.push_back(mk(1, rd(MIE), 0, 0, 0, 0, 0, 32'h800, 0, 0));
        tbl.push_back(mk(1, enc(MIE, 3, 3'b011), 32'h800, 0, 0, 0, 0, 32'h800, 0, 0));
        tbl.push_back(mk(1, rd(MIE), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, rd(12'h123), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, enc(MEP, 2, 3'b001), 32'h1237, 0, 0, 0, 0, 32'h64, 0, 0));
        tbl.push_back(mk(1, rd(MEP), 0, 0, 0, 0, 0, 32'h1234, 0, 0));
        // reset while draining a trap, then a fresh trap uses the reset mtvec
        tbl.push_back(mk(1, enc(MIE, 2, 3'b001), 32'h80, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h200, 0, 1, 0, 0, 1, 32'h100));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, enc(MST, 2, 3'b001), 32'h8, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, enc(MIE, 2, 3'b001), 32'h80, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 32'h300, 0, 1, 0, 0, 1, RMT));
        tbl.push_back(mk(1, rd(MEP), 0, 0, 0, 1, 0, 32'h300, 0, 0));
        tbl.push_back(mk(1, rd(MST), 0, 0, 0, 0, 0, 32'h80, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].r; instr = tbl[k].i; alu = tbl[k].a; pcf = tbl[k].p;
            stall = tbl[k].s; tirq = tbl[k].t; eirq = tbl[k].e;
            sample($sformatf("vec%0d", k));
            chk($sformatf("vec%0d tbl_rdata", k), csr_rdata, tbl[k].erd);
            chk($sformatf("vec%0d tbl_flush", k), {31'd0, csr_flush}, {31'd0, tbl[k].ef});
            if (tbl[k].ef) chk($sformatf("vec%0d tbl_redirect", k), csr_redirect, tbl[k].edr);
            advance();
        end

        for (int k = 0; k < 3000; k++) begin
            logic [11:0] alist [9];
            logic [2:0]  flist [6];
            int sel;
            alist = '{MST, MIE, MTV, MEP, MCA, MIP, MCY, MCH, 12'h123};
            flist = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
            rst   = ($urandom_range(0, 63) != 0);
            stall = ($urandom_range(0, 4) == 0);
            tirq  = ($urandom_range(0, 2) == 0);
            eirq  = ($urandom_range(0, 2) == 0);
            alu   = $urandom;
            pcf   = $urandom;
            sel   = $urandom_range(0, 9);
            if (sel == 0)      instr = 32'h0;
            else if (sel == 1) instr = MRET;
            else instr = enc(alist[$urandom_range(0, 8)],
                             ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                             flist[$urandom_range(0, 5)]);
            sample($sformatf("rnd%0d", k));
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
